// File: rtl/mem_data_initiator_pkg.sv
// Purpose: shared widths, derived constants and FSM state type for the data-memory initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_data_initiator_pkg;

    localparam int WORD_LEN = 16;                       // datapath word width
    localparam int ADDR_LEN = 16;                       // cell address width
    localparam int CELL_LEN = 8;                        // memory cell width
    localparam int CELLS    = WORD_LEN / CELL_LEN;      // cell accesses per word
    localparam int CNT_W    = (CELLS > 1) ? $clog2(CELLS) : 1;

    typedef logic [WORD_LEN-1:0] word_t;
    typedef logic [ADDR_LEN-1:0] addr_t;
    typedef logic [CELL_LEN-1:0] cell_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_data_initiator_if.sv
// Purpose: bundles the datapath request/response port and the cell-memory port.
// Latency: n/a (wires only).
// Backpressure: req_ready gates requests; responses and memory accesses have none.
// Ports: slave  = the initiator (takes requests, drives the memory);
//        master = the datapath + memory side (issues requests, returns cell data).
interface mem_data_initiator_if;
    import mem_data_initiator_pkg::*;

    logic  req_valid;
    logic  req_ready;
    logic  req_we;
    addr_t req_addr;
    word_t req_wdata;
    logic  resp_valid;
    word_t resp_rdata;
    addr_t mem_addr;
    cell_t mem_wdata;
    logic  mem_we;
    cell_t mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, mem_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/mem_data_initiator.sv
// Purpose: serialises one word load/store into CELLS big-endian single-cell memory accesses.
// Latency: accept at edge T, cell accesses in cycles T+1..T+CELLS, resp_valid pulse in T+CELLS+1.
// Backpressure: req_ready only in IDLE (requests while busy are dropped); no response backpressure.
// Ports: clk, rst (synchronous, active-high) and bus (slave modport: req_*, resp_*, mem_*).
module mem_data_initiator
    import mem_data_initiator_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    mem_data_initiator_if.slave   bus
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    addr_t            addr_l;
    word_t            wdata_l;
    logic             we_l;
    word_t            asm_r;      // word being assembled (load) or echoed (store)
    word_t            asm_nxt;
    word_t            resp_r;     // held until the next completed access
    word_t            wsh;        // wdata_l with the current cell moved to the top
    logic             accept;
    logic             last;

    assign bus.resp_rdata = resp_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.mem_we     = 1'b0;
        asm_nxt        = asm_r;
        accept         = 1'b0;
        last           = (cnt == CNT_W'(CELLS - 1));
        wsh            = wdata_l << (CELL_LEN * int'(cnt));

        case (state)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                bus.mem_addr  = addr_l + ADDR_LEN'(cnt);
                bus.mem_wdata = wsh[WORD_LEN-1 -: CELL_LEN];
                // A reset landing mid-store must not commit the cell of the
                // cycle it arrives in, so the strobe is cut immediately.
                bus.mem_we    = we_l & ~rst;
                if (we_l) begin
                    asm_nxt = wdata_l;
                end else begin
                    asm_nxt = (asm_r << CELL_LEN) | WORD_LEN'(bus.mem_rdata);
                end
                if (last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.resp_valid = 1'b1;
                state_nxt      = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            addr_l  <= '0;
            wdata_l <= '0;
            we_l    <= 1'b0;
            asm_r   <= '0;
            resp_r  <= '0;
        end else if (accept) begin
            addr_l  <= bus.req_addr;
            wdata_l <= bus.req_wdata;
            we_l    <= bus.req_we;
            cnt     <= '0;
        end else if (state == ST_XFER) begin
            asm_r <= asm_nxt;
            if (last) begin
                // Capture the finished word directly so resp_rdata is valid
                // during the DONE pulse and stays put afterwards.
                resp_r <= asm_nxt;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_data_initiator.sv
// Purpose: self-checking bench for mem_data_initiator against a 64 KiB cell memory and a word-level reference.
// Latency: checks exact cycle placement of every cell access and the response pulse.
// Backpressure: exercises held req_valid, busy-time request changes and reset interactions.
module tb_mem_data_initiator;
    import mem_data_initiator_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    mem_data_initiator_if bus();

    mem_data_initiator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory seen by the DUT, and the bench's own expectation of its contents.
    bit [CELL_LEN-1:0] mem_arr [0:(1<<ADDR_LEN)-1];
    bit [CELL_LEN-1:0] ref_mem [0:(1<<ADDR_LEN)-1];

    assign bus.mem_rdata = mem_arr[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_wdata;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Cell i of a word lives at address a+i, wrapping round the address space.
    function automatic addr_t cell_addr(input addr_t a, input int i);
        return ADDR_LEN'((int'(a) + i) % (1 << ADDR_LEN));
    endfunction

    // Big-endian: cell 0 is the most-significant slice of the word.
    function automatic cell_t cell_of(input word_t w, input int i);
        return CELL_LEN'(w >> (WORD_LEN - CELL_LEN * (i + 1)));
    endfunction

    function automatic word_t ref_load(input addr_t a);
        word_t w = '0;
        for (int i = 0; i < CELLS; i++) w = (w << CELL_LEN) | WORD_LEN'(ref_mem[cell_addr(a, i)]);
        return w;
    endfunction

    task automatic scramble_req();
        bus.req_valid = 1'($urandom_range(0, 1));
        bus.req_we    = 1'($urandom_range(0, 1));
        bus.req_addr  = ADDR_LEN'($urandom);
        bus.req_wdata = WORD_LEN'($urandom);
    endtask

    // One complete access from IDLE back to IDLE, checking every cycle.
    task automatic do_txn(input bit we, input addr_t a, input word_t wd, input string tag);
        word_t exp_w;
        chk({tag, ".ready_idle"}, bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        exp_w = we ? wd : ref_load(a);
        tick();
        for (int i = 0; i < CELLS; i++) begin
            scramble_req();
            chk({tag, ".ready_busy"}, bus.req_ready, 0);
            chk({tag, ".resp_early"}, bus.resp_valid, 0);
            chk({tag, ".mem_addr"}, bus.mem_addr, cell_addr(a, i));
            chk({tag, ".mem_we"}, bus.mem_we, we);
            if (we) begin
                chk({tag, ".mem_wdata"}, bus.mem_wdata, cell_of(wd, i));
                ref_mem[cell_addr(a, i)] = cell_of(wd, i);
            end
            tick();
        end
        scramble_req();
        chk({tag, ".resp_valid"}, bus.resp_valid, 1);
        chk({tag, ".resp_rdata"}, bus.resp_rdata, exp_w);
        chk({tag, ".ready_done"}, bus.req_ready, 0);
        chk({tag, ".mem_we_done"}, bus.mem_we, 0);
        bus.req_valid = 1'b0;
        tick();
        chk({tag, ".resp_pulse"}, bus.resp_valid, 0);
        chk({tag, ".resp_hold"}, bus.resp_rdata, exp_w);
    endtask

    initial begin
        addr_t a;
        word_t w;
        addr_t acc_a;
        word_t acc_w;
        int    per;
        int    pos;

        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        tick();
        tick();
        rst = 1'b0;

        chk("reset.ready", bus.req_ready, 1);
        chk("reset.resp_valid", bus.resp_valid, 0);
        chk("reset.resp_rdata", bus.resp_rdata, 0);
        chk("reset.mem_addr", bus.mem_addr, 0);
        chk("reset.mem_we", bus.mem_we, 0);
        chk("reset.mem_wdata", bus.mem_wdata, 0);

        do_txn(1'b1, 16'h0010, 16'hBEEF, "st_beef");
        chk("st_beef.cell10", mem_arr[16'h0010], 8'hBE);
        chk("st_beef.cell11", mem_arr[16'h0011], 8'hEF);
        do_txn(1'b0, 16'h0010, 16'h0000, "ld_beef");

        do_txn(1'b1, 16'hFFFF, 16'h1234, "st_wrap");
        chk("st_wrap.cellffff", mem_arr[16'hFFFF], 8'h12);
        chk("st_wrap.cell0000", mem_arr[16'h0000], 8'h34);
        do_txn(1'b0, 16'hFFFF, 16'h0000, "ld_wrap");

        // Random mix of loads and stores, biased toward a small window so
        // loads often see earlier stores, plus odd and wrapping addresses.
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 2))
                0:       a = ADDR_LEN'(16'h0100 + $urandom_range(0, 7));
                1:       a = ADDR_LEN'(16'hFFFD + $urandom_range(0, 4));
                default: a = ADDR_LEN'($urandom);
            endcase
            w = WORD_LEN'($urandom);
            do_txn(1'($urandom_range(0, 1)), a, w, "rand");
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                bus.req_valid = 1'b0;
                bus.req_addr  = ADDR_LEN'($urandom);
                tick();
                chk("rand.gap_mem_we", bus.mem_we, 0);
            end
        end
        for (int i = 0; i < 16; i++) begin
            chk("rand.mem_image", mem_arr[16'h0100 + i], ref_mem[16'h0100 + i]);
        end

        // req_valid held high with a new address every cycle: one accept per
        // CELLS+2 cycles, and the latched address alone drives mem_addr.
        per           = CELLS + 2;
        bus.req_we    = 1'b0;
        bus.req_valid = 1'b1;
        for (int c = 0; c < 5 * per; c++) begin
            bus.req_addr = ADDR_LEN'(16'h000E + $urandom_range(0, 6));
            pos = c % per;
            chk("held.ready", bus.req_ready, (pos == 0) ? 1 : 0);
            if (pos == 0) begin
                acc_a = bus.req_addr;
                acc_w = ref_load(acc_a);
            end else if (pos <= CELLS) begin
                chk("held.mem_addr", bus.mem_addr, cell_addr(acc_a, pos - 1));
                chk("held.mem_we", bus.mem_we, 0);
            end else begin
                chk("held.resp_valid", bus.resp_valid, 1);
                chk("held.resp_rdata", bus.resp_rdata, acc_w);
            end
            tick();
        end
        bus.req_valid = 1'b0;

        // Reset in the second cell cycle of a store: first cell committed,
        // second left alone, no response.
        do_txn(1'b1, 16'h0020, 16'h5566, "pre_rst");
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 16'h0020;
        bus.req_wdata = 16'hAAAA;
        tick();
        bus.req_valid = 1'b0;
        chk("midrst.c1_addr", bus.mem_addr, 16'h0020);
        chk("midrst.c1_we", bus.mem_we, 1);
        chk("midrst.c1_wdata", bus.mem_wdata, 8'hAA);
        ref_mem[16'h0020] = 8'hAA;
        tick();
        chk("midrst.c2_addr", bus.mem_addr, 16'h0021);
        rst = 1'b1;
        #1;
        chk("midrst.c2_we_cut", bus.mem_we, 0);
        tick();
        rst = 1'b0;
        chk("midrst.ready", bus.req_ready, 1);
        chk("midrst.resp_valid", bus.resp_valid, 0);
        chk("midrst.resp_rdata", bus.resp_rdata, 0);
        chk("midrst.mem_we", bus.mem_we, 0);
        tick();
        chk("midrst.no_resp", bus.resp_valid, 0);
        chk("midrst.cell20", mem_arr[16'h0020], 8'hAA);
        chk("midrst.cell21", mem_arr[16'h0021], 8'h66);
        do_txn(1'b0, 16'h0020, 16'h0000, "ld_after_rst");

        // Reset and a request in the same cycle: the request is dropped.
        rst           = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 16'h0030;
        bus.req_wdata = 16'h9999;
        tick();
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        chk("rstreq.ready", bus.req_ready, 1);
        chk("rstreq.mem_we", bus.mem_we, 0);
        chk("rstreq.mem_addr", bus.mem_addr, 0);
        chk("rstreq.mem_wdata", bus.mem_wdata, 0);
        chk("rstreq.resp_valid", bus.resp_valid, 0);
        tick();
        chk("rstreq.idle_we", bus.mem_we, 0);
        chk("rstreq.idle_resp", bus.resp_valid, 0);
        chk("rstreq.cell30", mem_arr[16'h0030], ref_mem[16'h0030]);
        chk("rstreq.cell31", mem_arr[16'h0031], ref_mem[16'h0031]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
